issue_scoreboard: RTL

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/hcu_pkg.sv | 9 +
 rtl/issue_lane_check.sv | 29 ++
 rtl/issue_scoreboard.sv | 79 +++++++
 3 files changed

// File: rtl/hcu_pkg.sv
// hcu_pkg: shared register-index type, latency default and counter sizing for the issue scoreboard
package hcu_pkg;
  localparam int NREGS_DEF = 8;
  localparam int WB_LAT_DEF = 3;
  typedef logic [$clog2(NREGS_DEF)-1:0] reg_idx_t;
  function automatic int cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction
endpackage

// File: rtl/issue_lane_check.sv
// issue_lane_check: source readiness plus intra-bundle RAW/WAW check against all older lanes
module issue_lane_check #(
  parameter int LANES = 2,
  parameter int NREGS = 8,
  parameter int LANE = 0,
  localparam int RW = $clog2(NREGS)
) (
  input  logic                valid,
  input  logic [RW-1:0]       rs_a,
  input  logic [RW-1:0]       rs_b,
  input  logic                rs_a_used,
  input  logic                rs_b_used,
  input  logic [LANES*RW-1:0] rd,
  input  logic [LANES-1:0]    rd_we,
  input  logic [NREGS-1:0]    ready,
  output logic                ok
);
  logic hazard;
  always_comb begin
    hazard = 1'b0;
    for (int j = 0; j < LANES; j++)
      if (j < LANE && rd_we[j] &&
          ((rs_a_used && rs_a == rd[j*RW +: RW]) ||
           (rs_b_used && rs_b == rd[j*RW +: RW]) ||
           (rd_we[LANE] && rd[LANE*RW +: RW] == rd[j*RW +: RW])))
        hazard = 1'b1;
  end
  assign ok = valid && !hazard && (!rs_a_used || ready[rs_a]) && (!rs_b_used || ready[rs_b]);
endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: in-order multi-lane issue gate with per-register writeback countdown.
// Define ISSUE_SCOREBOARD_FWD_EN to treat a source one cycle from writeback as ready (bypass).
module issue_scoreboard
  import hcu_pkg::*;
#(
  parameter int LANES = 2,
  parameter int NREGS = NREGS_DEF,
  parameter int WB_LAT = WB_LAT_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [LANES-1:0]              valid_i,
  input  logic [LANES*$clog2(NREGS)-1:0] rs_a_i,
  input  logic [LANES*$clog2(NREGS)-1:0] rs_b_i,
  input  logic [LANES-1:0]              rs_a_used_i,
  input  logic [LANES-1:0]              rs_b_used_i,
  input  logic [LANES*$clog2(NREGS)-1:0] rd_i,
  input  logic [LANES-1:0]              rd_we_i,
  input  logic                          flush_i,
  output logic [LANES-1:0]              issue_o,
  output logic [NREGS-1:0]              busy_o,
  output logic [15:0]                   stall_cnt_o
);
  localparam int RW = $clog2(NREGS);
  localparam int CW = cnt_w(WB_LAT);
  logic [NREGS-1:0][CW-1:0] cnt;
  logic [NREGS-1:0] ready, load;
  logic [LANES-1:0] ok;
  logic go;
  always_comb begin
    busy_o = '0;
    ready = '0;
    for (int r = 0; r < NREGS; r++) begin
      busy_o[r] = cnt[r] != '0;
`ifdef ISSUE_SCOREBOARD_FWD_EN
      ready[r] = cnt[r] <= CW'(1);
`else
      ready[r] = cnt[r] == '0;
`endif
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    issue_lane_check #(.LANES(LANES), .NREGS(NREGS), .LANE(i)) u_chk (
      .valid(valid_i[i]),
      .rs_a(rs_a_i[i*RW +: RW]),
      .rs_b(rs_b_i[i*RW +: RW]),
      .rs_a_used(rs_a_used_i[i]),
      .rs_b_used(rs_b_used_i[i]),
      .rd(rd_i),
      .rd_we(rd_we_i),
      .ready(ready),
      .ok(ok[i])
    );
  end
  // a lane issues only if every older lane did, keeping issue an in-order prefix
  always_comb begin
    issue_o = '0;
    go = !flush_i && !reset;
    for (int i = 0; i < LANES; i++) begin
      issue_o[i] = go && ok[i];
      go = issue_o[i];
    end
  end
  always_comb begin
    load = '0;
    for (int i = 0; i < LANES; i++)
      if (issue_o[i] && rd_we_i[i]) load[rd_i[i*RW +: RW]] = 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      stall_cnt_o <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++)
        cnt[r] <= load[r] ? CW'(WB_LAT) : (cnt[r] != '0 ? cnt[r] - CW'(1) : cnt[r]);
      if (valid_i[0] && !issue_o[0] && stall_cnt_o != 16'hFFFF)
        stall_cnt_o <= stall_cnt_o + 16'd1;
    end
endmodule
